// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART transmit definitions: frame levels, bit counts and the
// serializer state encoding used by the FIFO-backed transmitter.
package uart_tx_fifo_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Occupancy counters need one extra bit so that "completely full" is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-push side and line/status side of the FIFO-backed UART transmitter.
// The producer uses the master modport; the transmitter uses slave.
interface uart_tx_fifo_if
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 16
) ();

    logic [DATA_BITS-1:0]          data;
    logic                          data_strobe;
    logic                          ready;
    logic                          serial;
    logic                          busy;
    logic [count_width(DEPTH)-1:0] count;
    logic                          overflow;

    modport master (
        output data, data_strobe,
        input  ready, serial, busy, count, overflow
    );

    modport slave (
        input  data, data_strobe,
        output ready, serial, busy, count, overflow
    );

endinterface

// File: rtl/uart_tx_fifo_fifo_sync.sv
// Single-clock FIFO with registered occupancy count. A push while full is
// ignored even when a pop happens in the same cycle, so the caller can treat
// "full" as a hard reject. Depth must be a power of two so the pointers wrap
// naturally.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array is not reset; emptiness is tracked by pointers and count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-backed 8N1 UART transmitter. Bytes are queued through the bus, and the
// serializer pops them one at a time, advancing only on baud_x1 strobes
// supplied by an external divider. Back-to-back frames run with no idle gap.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic          mclk,
    input  logic          reset,
    input  logic          baud_x1,
    uart_tx_fifo_if.slave bus
);

    localparam int CW = count_width(DEPTH);

    tx_state_t            state;
    tx_state_t            state_next;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic [BIT_IDX_W-1:0] bit_idx_next;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_next;
    logic                 serial_q;
    logic                 serial_next;
    logic                 overflow_q;

    logic                 pop;
    logic [DATA_BITS-1:0] head;
    logic                 full;
    logic                 empty;
    logic [CW-1:0]        fifo_count;

    fifo_sync #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (mclk),
        .reset   (reset),
        .push    (bus.data_strobe),
        .pop     (pop),
        .wr_data (bus.data),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    assign bus.ready    = !full;
    assign bus.serial   = serial_q;
    assign bus.busy     = (state != ST_IDLE);
    assign bus.count    = fifo_count;
    assign bus.overflow = overflow_q;

    // Sticky record that a byte was rejected because the queue was full.
    always_ff @(posedge mclk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (bus.data_strobe && full) begin
            overflow_q <= 1'b1;
        end
    end

    // Serializer registers; the line itself is registered so it never glitches.
    always_ff @(posedge mclk) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_idx  <= '0;
            shift    <= '0;
            serial_q <= IDLE_LEVEL;
        end else begin
            state    <= state_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
            serial_q <= serial_next;
        end
    end

    // Frame sequencing: every move happens on a baud strobe, and STOP chains straight into the next START.
    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        serial_next  = serial_q;
        pop          = 1'b0;

        unique case (state)
            ST_IDLE: begin
                serial_next = IDLE_LEVEL;
                if (baud_x1 && !empty) begin
                    pop         = 1'b1;
                    shift_next  = head;
                    state_next  = ST_START;
                    serial_next = START_LEVEL;
                end
            end
            ST_START: begin
                if (baud_x1) begin
                    state_next   = ST_DATA;
                    bit_idx_next = '0;
                    serial_next  = shift[0];
                end
            end
            ST_DATA: begin
                if (baud_x1) begin
                    if (bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
                        state_next  = ST_STOP;
                        serial_next = STOP_LEVEL;
                    end else begin
                        bit_idx_next = bit_idx + BIT_IDX_W'(1);
                        serial_next  = shift[bit_idx_next];
                    end
                end
            end
            ST_STOP: begin
                if (baud_x1) begin
                    if (!empty) begin
                        pop         = 1'b1;
                        shift_next  = head;
                        state_next  = ST_START;
                        serial_next = START_LEVEL;
                    end else begin
                        state_next  = ST_IDLE;
                        serial_next = IDLE_LEVEL;
                    end
                end
            end
            default: begin
                state_next  = ST_IDLE;
                serial_next = IDLE_LEVEL;
            end
        endcase
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in bytes; it SHALL be a power of two and at least 2.
REQ-002 SHALL have port mclk  input  1  system clock, 48 MHz, the only clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on posedge mclk.
REQ-004 SHALL have port baud_x1  input  1  one-mclk-wide strobe, once per bit period.
REQ-005 SHALL have port data  input  8  byte to enqueue.
REQ-006 SHALL have port data_strobe  input  1  push request, one mclk per byte.
REQ-007 SHALL have port ready  output  1  high when the FIFO is not full.
REQ-008 SHALL have port serial  output  1  UART line, 8N1, idles high.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress (any state other than IDLE).
REQ-010 SHALL have port count  output  log2(DEPTH)+1  bytes currently queued, excluding the byte being shifted.
REQ-011 SHALL have port overflow  output  1  sticky flag: a push was dropped.

Function
REQ-012 SHALL accept a push when data_strobe=1 and ready=1 in the same cycle; count increments at the next edge.
REQ-013 SHALL drop the byte when data_strobe=1 and ready=0, even if a pop occurs in the same cycle; overflow SHALL be set at the next edge and held until reset.
REQ-014 SHALL leave count unchanged when a push and a pop occur in the same cycle.
REQ-015 SHALL derive ready combinationally from registered count (ready = count != DEPTH).
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP; every transition SHALL occur only on a cycle with baud_x1=1.
REQ-017 IDLE: serial=1; on baud_x1 with count>0, SHALL pop the head byte into the shift register, go to START and drive serial=0 from the next edge.
REQ-018 SHALL not pop a byte in the same cycle it is pushed into an empty FIFO (no fall-through); that byte starts at a later baud_x1.
REQ-019 START: on baud_x1 SHALL go to DATA with bit index 0 and output bit 0 (LSB).
REQ-020 DATA: on baud_x1 SHALL output the next bit, LSB first; after bit 7 has lasted one period, SHALL go to STOP with serial=1.
REQ-021 STOP: on baud_x1 with count>0 SHALL pop and go directly to START (no idle gap); otherwise SHALL go to IDLE.
REQ-022 Each of the 10 bits in a frame SHALL last exactly one baud_x1 interval; serial SHALL be registered (glitch-free).
REQ-023 baud_x1 SHALL have no effect on the FIFO contents except through the pops in REQ-017 and REQ-021.
REQ-024 FIFO read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.

Reset
REQ-025 Reset SHALL set the state to IDLE, serial=1, busy=0, count=0, ready=1, overflow=0, and empty the FIFO.
REQ-026 Reset mid-frame SHALL abort the frame: serial=1 from the next edge, and queued bytes SHALL be discarded.
REQ-027 Reset SHALL dominate data_strobe and baud_x1 in the same cycle.

Structure
REQ-028 Frame constants (DATA_BITS=8, START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1) and the FSM state encodings SHALL live in the shared common include, alongside the existing UART definitions.
REQ-029 Storage SHALL be a sub-module fifo_sync (parameters WIDTH, DEPTH; signals push, pop, full, empty, count); the serializer FSM SHALL be in uart_tx_fifo.
REQ-030 The block SHALL use the existing divide_by_n as the baud_x1 source at integration; it SHALL contain no baud divider itself.

Verification
REQ-031 baud_x1 every 16 mclk, push 0xA5 when idle -> serial 0,1,0,1,0,0,1,0,1,1 with each bit 16 mclk wide, then idle high; busy=1 exactly for the frame.
REQ-032 Push 0x00 then 0xFF on consecutive cycles -> 20 contiguous bit periods (0 then 8x0, 1, 0 then 8x1, 1) with no idle gap; count 2->1->0.
REQ-033 With baud_x1 held low, push 17 bytes with DEPTH=16 -> ready=0 after the 16th, overflow=1 after the 17th; enabling baud shows exactly bytes 1-16, in order.
REQ-034 When full, assert a push in the same cycle STOP pops -> push dropped, overflow=1, count goes to 15.
REQ-035 Assert reset during DATA bit 3 with 4 bytes queued -> next edge serial=1, busy=0, count=0, ready=1; no further frames are sent.
REQ-036 Push 0x3C in the same cycle as baud_x1 with the FIFO empty -> serial stays high that period; the start bit begins at the following baud_x1.
